fp_divider_seq: RTL
===================

FP_DIVIDER_SEQ -- requirements
Module: fp_divider_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL provide: clk  input  1  rising-edge clock.
REQ-003 SHALL provide: rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide: a  input  32  IEEE-754 single-precision dividend.
REQ-006 SHALL provide: b  input  32  IEEE-754 single-precision divisor.
REQ-007 SHALL provide: busy  output  1  high from the cycle after start is accepted until done.
REQ-008 SHALL provide: done  output  1  one-cycle pulse; result and flags valid.
REQ-009 SHALL provide: result  output  32  quotient a/b; held until the next accepted start.
REQ-010 SHALL provide: flags  output  4  {invalid, div_by_zero, overflow, underflow}; held with result.

Function
REQ-011 SHALL capture a and b on the edge where state is IDLE and start=1; later input changes have no effect on that operation.
REQ-012 SHALL ignore start in every state other than IDLE.
REQ-013 SHALL step through states IDLE -> CHECK -> DIV (26 cycles) -> NORM -> RND -> DONE -> IDLE for normal operands.
REQ-014 SHALL take CHECK -> DONE directly for special operands; done is asserted 2 cycles after the accept edge.
REQ-015 SHALL assert done 30 cycles after the accept edge for normal operands.
REQ-016 SHALL set the sign to a[31] XOR b[31] for all non-NaN results.
REQ-017 SHALL treat exponent 0 (zero or denormal) as signed zero; denormal results are flushed to signed zero with underflow=1.
REQ-018 SHALL form the exponent as ea - eb + 127 in 10-bit signed arithmetic.
REQ-019 SHALL divide the 24-bit significands by restoring division, one quotient bit per DIV cycle: 24 bits plus guard and round; sticky is the OR of the final remainder.
REQ-020 SHALL, in NORM, shift the quotient left by 1 and decrement the exponent when the quotient MSB is 0.
REQ-021 SHALL, in RND, increment the exponent on a mantissa carry-out.
REQ-022 SHALL return signed infinity with overflow=1 when the final exponent is >= 255.
REQ-023 SHALL return signed zero with underflow=1 when the final exponent is <= 0.
REQ-024 SHALL return 0x7FC00000 with invalid=1 for NaN input, 0/0 and inf/inf; NaN input alone leaves invalid=0.
REQ-025 SHALL return signed infinity with div_by_zero=1 for finite nonzero/0.
REQ-026 SHALL return signed infinity, no flags, for inf/finite.
REQ-027 SHALL return signed zero, no flags, for 0/finite nonzero and finite/inf.

Reset
REQ-028 SHALL, on rst=1 at a clock edge in any state including mid-DIV, go to IDLE with busy=0, done=0, result=0, flags=0.
REQ-029 SHALL let rst take priority over start on the same edge.

Configuration
REQ-030 SHALL, with FP_DIV_RNE_EN defined, round to nearest even using the guard, round and sticky bits.
REQ-031 SHALL, without FP_DIV_RNE_EN, truncate toward zero; latency is unchanged (RND still occupies one cycle).

Structure
REQ-032 SHALL keep in package fp_div_pkg: field widths, bias 127, the QNAN constant 0x7FC00000, the state enumeration and the flag bit indices.
REQ-033 SHALL place operand classification (zero/inf/NaN/normal) in combinational sub-module fp_classify, instantiated once per operand.

Verification
REQ-034 SHALL cover: a=0x40C00000, b=0x40000000 -> result 0x40400000, flags 0, done at cycle 30.
REQ-035 SHALL cover: a=b=0x42AA4000 -> result 0x3F800000, flags 0.
REQ-036 SHALL cover: a=0x3F800000, b=0x40400000 -> 0x3EAAAAAB with FP_DIV_RNE_EN, 0x3EAAAAAA without.
REQ-037 SHALL cover: a=0x3F800000, b=0 -> result 0x7F800000, div_by_zero=1 at cycle 2; a=b=0 -> result 0x7FC00000, invalid=1.
REQ-038 SHALL cover: a=0x7F7FFFFF, b=0x3F000000 -> result 0x7F800000, overflow=1.
REQ-039 SHALL cover: start pulsed during DIV -> ignored and the first result is unchanged; rst at DIV cycle 10 -> IDLE, outputs 0, and the next start completes normally.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared constants, state encoding and operand class record for the
// sequential single-precision divider.
package fp_div_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIG_W    = 24;
    localparam int QUO_W    = 26;   // 24 significand bits + guard + round
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [4:0]  DIV_LAST = 5'd25;   // 26 DIV cycles, counted down to 0

    localparam int FLG_INV = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_NORM,
        S_RND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic zero;     // exponent 0: zero or denormal, both treated as zero
        logic inf;
        logic nan;
        logic normal;
    } fp_class_t;

endpackage

// File: rtl/fp_divider_seq_if.sv
// Request/response bundle between a requester and the divider.
interface fp_divider_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp_classify.sv
// Combinational classification of one single-precision operand.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [30:0] x_i,
    output fp_class_t   cls_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = x_i[30:23];
    assign frac_f = x_i[FRAC_W-1:0];

    // Decode exponent/fraction into exactly one class bit.
    always_comb begin
        cls_o = '0;
        if (exp_f == '0) begin
            cls_o.zero = 1'b1;
        end else if (exp_f == '1) begin
            if (frac_f == '0) cls_o.inf = 1'b1;
            else              cls_o.nan = 1'b1;
        end else begin
            cls_o.normal = 1'b1;
        end
    end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per cycle.
// Build option: FP_DIV_RNE_EN selects round-to-nearest-even; otherwise the
// quotient is truncated toward zero. Latency is the same in both builds.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on accept
// CHECK   | classify operands; specials go straight to DONE
// DIV     | restoring division, 26 quotient bits
// NORM    | shift quotient left once if its MSB is 0
// RND     | round, detect overflow/underflow, write result
// DONE    | one-cycle done pulse
module fp_divider_seq
    import fp_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fp_divider_seq_if.slave  bus
);

    state_t             state_q, state_d;
    logic [31:0]        a_q, b_q;
    logic [SIG_W:0]     rem_q;
    logic [QUO_W-1:0]   q_q;
    logic signed [9:0]  exp_q;
    logic [4:0]         cnt_q;
    logic [31:0]        result_q;
    logic [3:0]         flags_q;

    fp_class_t          cls_a, cls_b;
    logic               sign, special, busy, done;
    logic [31:0]        spec_res, rnd_res;
    logic [3:0]         spec_flg, rnd_flg;
    logic [SIG_W-1:0]   mb, mant;
    logic               ge, inc;
    logic [SIG_W:0]     rem_n, sum;
    logic signed [9:0]  exp_init, exp_r;
    logic [FRAC_W-1:0]  frac_r;

    fp_classify u_cls_a (.x_i(a_q[30:0]), .cls_o(cls_a));
    fp_classify u_cls_b (.x_i(b_q[30:0]), .cls_o(cls_b));

    assign sign     = a_q[31] ^ b_q[31];
    assign special  = !(cls_a.normal && cls_b.normal);
    assign mb       = {1'b1, b_q[FRAC_W-1:0]};
    assign exp_init = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                      + 10'(EXP_BIAS);

    // One restoring step: the remainder stays below 2*mb, so 25 bits suffice.
    assign ge    = (rem_q >= {1'b0, mb});
    assign rem_n = ge ? (rem_q - {1'b0, mb}) : rem_q;

    // Result for zero/inf/NaN operands, decided in CHECK.
    always_comb begin
        spec_res = {sign, 31'b0};
        spec_flg = '0;
        if (cls_a.nan || cls_b.nan) begin
            spec_res = QNAN;
        end else if ((cls_a.zero && cls_b.zero) || (cls_a.inf && cls_b.inf)) begin
            spec_res          = QNAN;
            spec_flg[FLG_INV] = 1'b1;
        end else if (cls_a.inf) begin
            spec_res = {sign, 8'hFF, 23'b0};
        end else if (cls_b.zero) begin
            spec_res          = {sign, 8'hFF, 23'b0};
            spec_flg[FLG_DBZ] = 1'b1;
        end
    end

    // Rounding and range check of the normalised quotient.
    always_comb begin
        mant = q_q[QUO_W-1:2];
`ifdef FP_DIV_RNE_EN
        inc  = q_q[1] & (q_q[0] | (|rem_q) | mant[0]);
`else
        inc  = 1'b0;
`endif
        sum     = {1'b0, mant} + {{SIG_W{1'b0}}, inc};
        exp_r   = exp_q + (sum[SIG_W] ? 10'sd1 : 10'sd0);
        frac_r  = sum[SIG_W] ? sum[SIG_W-1:1] : sum[FRAC_W-1:0];
        rnd_flg = '0;
        if (exp_r >= 10'sd255) begin
            rnd_res          = {sign, 8'hFF, 23'b0};
            rnd_flg[FLG_OVF] = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            rnd_res          = {sign, 31'b0};
            rnd_flg[FLG_UNF] = 1'b1;
        end else begin
            rnd_res = {sign, exp_r[7:0], frac_r};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CHECK;
            S_CHECK: begin
                busy    = 1'b1;
                state_d = special ? S_DONE : S_DIV;
            end
            S_DIV: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = S_NORM;
            end
            S_NORM: begin
                busy    = 1'b1;
                state_d = S_RND;
            end
            S_RND: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, division datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                S_CHECK: begin
                    if (special) begin
                        result_q <= spec_res;
                        flags_q  <= spec_flg;
                    end else begin
                        rem_q <= {1'b0, 1'b1, a_q[FRAC_W-1:0]};
                        q_q   <= '0;
                        exp_q <= exp_init;
                        cnt_q <= DIV_LAST;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_n << 1;
                    q_q   <= {q_q[QUO_W-2:0], ge};
                    if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
                end
                S_NORM: begin
                    if (!q_q[QUO_W-1]) begin
                        q_q   <= q_q << 1;
                        exp_q <= exp_q - 10'sd1;
                    end
                end
                S_RND: begin
                    result_q <= rnd_res;
                    flags_q  <= rnd_flg;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule
